// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filters: FSM encoding and
// the width helpers used to size the product and accumulator paths.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_OUTPUT = 2'd2
  } fir_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int prod_width(input int data_w, input int coeff_w);
    return data_w + coeff_w;
  endfunction

  // Headroom of clog2(taps) bits means the sum of all products cannot overflow.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up and saturate a fixed-point accumulator down to OUT_WIDTH.
// Purely combinational so any filter in the codebase can reuse it.
module fir_round_sat #(
  parameter int ACC_WIDTH            = 35,
  parameter int COEFF_FRACTION_WIDTH = 15,
  parameter int OUT_WIDTH            = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        sat_o
);

  // One extra bit so adding the half-LSB bias can never wrap.
  localparam int EXT_W = ACC_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (COEFF_FRACTION_WIDTH - 1);
  localparam logic signed [EXT_W-1:0] MAXV = (EXT_W'(1) <<< (OUT_WIDTH - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MINV = -(EXT_W'(1) <<< (OUT_WIDTH - 1));

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  assign biased  = {acc_i[ACC_WIDTH-1], acc_i} + HALF;
  assign shifted = biased >>> COEFF_FRACTION_WIDTH;

  always_comb begin
    data_o = shifted[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (shifted > MAXV) begin
      data_o = MAXV[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (shifted < MINV) begin
      data_o = MINV[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_ntap_hardware_share.sv
// N-tap FIR that walks the taps one per cycle through a single multiplier,
// with loadable coefficients and valid/ready handshakes on both streams.
module fir_ntap_hardware_share
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH           = 16,
  parameter int COEFF_WIDTH          = 16,
  parameter int COEFF_FRACTION_WIDTH = 15,
  parameter int NUM_TAPS             = 8,
  parameter int OUT_WIDTH            = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic signed [DATA_WIDTH-1:0]      i_data,
  input  logic                              i_data_valid,
  output logic                              o_data_ready,
  input  logic                              i_coeff_we,
  input  logic [clog2(NUM_TAPS)-1:0]        i_coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0]     i_coeff_data,
  input  logic                              i_flush,
  output logic signed [OUT_WIDTH-1:0]       o_data,
  output logic                              o_sat,
  output logic                              o_data_valid,
  input  logic                              i_out_ready
);

  localparam int TAP_W      = clog2(NUM_TAPS);
  localparam int PROD_WIDTH = prod_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  fir_state_e state_q, state_d;
  logic [TAP_W-1:0]              cnt_q;
  logic signed [DATA_WIDTH-1:0]  x_q    [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [OUT_WIDTH-1:0]   data_q;
  logic                          sat_q;

  logic                          idle, accept, last_tap, addr_ok;
  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [COEFF_WIDTH-1:0] c_sel;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [OUT_WIDTH-1:0]   rs_data;
  logic                          rs_sat;

  assign idle     = (state_q == ST_IDLE);
  // Flush has priority over a sample arriving in the same cycle.
  assign accept   = idle && i_data_valid && !i_flush;
  assign last_tap = (cnt_q == LAST_TAP);
  assign addr_ok  = ({1'b0, i_coeff_addr} < (TAP_W + 1)'(NUM_TAPS));

  // Shared multiplier: operands selected by the tap counter.
  assign x_sel   = x_q[cnt_q];
  assign c_sel   = coef_q[cnt_q];
  assign prod    = PROD_WIDTH'(x_sel) * PROD_WIDTH'(c_sel);
  assign acc_sum = acc_q + ACC_WIDTH'(prod);

  fir_round_sat #(
    .ACC_WIDTH           (ACC_WIDTH),
    .COEFF_FRACTION_WIDTH(COEFF_FRACTION_WIDTH),
    .OUT_WIDTH           (OUT_WIDTH)
  ) u_round_sat (
    .acc_i (acc_sum),
    .data_o(rs_data),
    .sat_o (rs_sat)
  );

  always_comb begin
    state_d      = state_q;
    o_data_ready = 1'b0;
    o_data_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_data_ready = 1'b1;
        if (accept) state_d = ST_MAC;
      end
      ST_MAC: begin
        if (last_tap) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        o_data_valid = 1'b1;
        if (i_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (idle && i_flush) begin
        for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
      end else if (accept) begin
        x_q[0] <= i_data;
        for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (accept) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (state_q == ST_MAC) begin
        acc_q <= acc_sum;
        cnt_q <= last_tap ? '0 : cnt_q + TAP_W'(1);
        if (last_tap) begin
          data_q <= rs_data;
          sat_q  <= rs_sat;
        end
      end
      if (idle && i_coeff_we && addr_ok) coef_q[i_coeff_addr] <= i_coeff_data;
    end
  end

  assign o_data = data_q;
  assign o_sat  = sat_q;

endmodule

// File: tb/tb_fir_ntap_hardware_share.sv
// Randomised and directed bench for fir_ntap_hardware_share against a
// plain-arithmetic convolution model of the filter.
module tb_fir_ntap_hardware_share;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic signed [15:0] i_data;
  logic               i_data_valid;
  logic               o_data_ready;
  logic               i_coeff_we;
  logic [1:0]         i_coeff_addr;
  logic signed [15:0] i_coeff_data;
  logic               i_flush;
  logic signed [15:0] o_data;
  logic               o_sat;
  logic               o_data_valid;
  logic               i_out_ready;

  // Second instance with a non-power-of-two tap count, for out-of-range writes.
  logic signed [15:0] b_data;
  logic               b_valid, b_ready, b_we, b_sat, b_ovalid;
  logic [2:0]         b_addr;
  logic signed [15:0] b_cdata, b_odata;

  int checks = 0;
  int errors = 0;
  longint mx[N];
  longint mc[N];

  fir_ntap_hardware_share #(.NUM_TAPS(N)) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data), .i_flush(i_flush), .o_data(o_data), .o_sat(o_sat),
    .o_data_valid(o_data_valid), .i_out_ready(i_out_ready)
  );

  fir_ntap_hardware_share #(.NUM_TAPS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .i_data(b_data), .i_data_valid(b_valid),
    .o_data_ready(b_ready), .i_coeff_we(b_we), .i_coeff_addr(b_addr),
    .i_coeff_data(b_cdata), .i_flush(1'b0), .o_data(b_odata), .o_sat(b_sat),
    .o_data_valid(b_ovalid), .i_out_ready(1'b1)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product of history and coefficients, round half up, clip.
  function automatic longint model_raw();
    longint acc;
    acc = 0;
    for (int i = 0; i < N; i++) acc += mx[i] * mc[i];
    return (acc + 64'sd16384) >>> 15;
  endfunction

  function automatic longint clip16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
  endtask

  task automatic wr_coef(input logic [1:0] addr, input logic signed [15:0] val);
    i_coeff_we = 1'b1; i_coeff_addr = addr; i_coeff_data = val;
    tick();
    i_coeff_we = 1'b0;
    mc[addr] = longint'(val);
    check("wr_rdy", o_data_ready, 1);
  endtask

  task automatic flush(input logic with_valid);
    i_flush = 1'b1; i_data_valid = with_valid; i_data = 16'sd1234;
    tick();
    i_flush = 1'b0; i_data_valid = 1'b0;
    for (int i = 0; i < N; i++) mx[i] = 0;
    check("flush_rdy", o_data_ready, 1);
    check("flush_vld", o_data_valid, 0);
  endtask

  task automatic send(input logic signed [15:0] d, input int hold, input logic wr_en,
                      input logic [1:0] wr_addr, input logic signed [15:0] wr_val,
                      input logic mac_we);
    longint raw, ex;
    int lat;
    logic signed [15:0] held;
    check("rdy_idle", o_data_ready, 1);
    i_data = d; i_data_valid = 1'b1; i_out_ready = 1'b0;
    if (wr_en) begin
      i_coeff_we = 1'b1; i_coeff_addr = wr_addr; i_coeff_data = wr_val;
    end
    tick();
    i_data_valid = 1'b0; i_coeff_we = 1'b0;
    if (wr_en) mc[wr_addr] = longint'(wr_val);
    for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = longint'(d);
    raw = model_raw();
    ex  = clip16(raw);
    check("rdy_busy", o_data_ready, 0);
    if (mac_we) begin
      i_coeff_we = 1'b1; i_coeff_addr = 2'd0; i_coeff_data = 16'sh7FFF;
    end
    lat = 0;
    while (o_data_valid !== 1'b1 && lat < 4 * N) begin
      tick();
      i_coeff_we = 1'b0;
      lat++;
    end
    check("latency", lat, N);
    check("data", o_data, ex);
    check("sat", o_sat, (raw != ex) ? 1 : 0);
    held = o_data;
    repeat (hold) begin
      tick();
      check("bp_vld", o_data_valid, 1);
      check("bp_data", o_data, held);
      check("bp_rdy", o_data_ready, 0);
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check("hs_rdy", o_data_ready, 1);
    check("hs_vld", o_data_valid, 0);
  endtask

  task automatic impulse_test();
    wr_coef(2'd0, 16'sh1000);
    wr_coef(2'd1, 16'sh2000);
    wr_coef(2'd2, 16'sh2000);
    wr_coef(2'd3, 16'sh1000);
    flush(1'b0);
    send(16'sd1000, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    repeat (4) send(16'sd0, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; i_data = '0; i_data_valid = 1'b0; i_coeff_we = 1'b0;
    i_coeff_addr = '0; i_coeff_data = '0; i_flush = 1'b0; i_out_ready = 1'b0;
    b_data = '0; b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_cdata = '0;
    model_clear_all();
    repeat (3) tick();
    check("rst_rdy", o_data_ready, 1);
    check("rst_vld", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_sat", o_sat, 0);
    reset_n = 1'b1;
    tick();

    // Out-of-range coefficient addresses on the 5-tap instance
    b_we = 1'b1; b_addr = 3'd0; b_cdata = 16'sh4000;
    tick();
    b_addr = 3'd5; b_cdata = 16'sh7FFF;
    tick();
    b_addr = 3'd7;
    tick();
    b_we = 1'b0; b_data = 16'sd2; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    lat = 0;
    while (b_ovalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("n5_latency", lat, 5);
    check("n5_data", b_odata, 1);
    check("n5_sat", b_sat, 0);
    tick();

    impulse_test();

    // Rounding
    wr_coef(2'd0, 16'sh4000);
    wr_coef(2'd1, 16'sd0);
    wr_coef(2'd2, 16'sd0);
    wr_coef(2'd3, 16'sd0);
    flush(1'b0);
    send(16'sd3, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    flush(1'b0);
    send(-16'sd3, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    send(16'sd1, 0, 1'b0, 2'd0, 16'sd0, 1'b0);

    // Saturation both directions, with backpressure on the last one
    for (int i = 0; i < N; i++) wr_coef(2'(i), 16'sh7FFF);
    flush(1'b0);
    repeat (4) send(16'sd32767, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    flush(1'b0);
    repeat (3) send(-16'sd32768, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    send(-16'sd32768, 10, 1'b0, 2'd0, 16'sd0, 1'b0);

    // Dropped write during MAC, then flush racing a valid sample
    wr_coef(2'd0, 16'sh0800);
    send(16'sd500, 2, 1'b0, 2'd0, 16'sd0, 1'b1);
    send(16'sd700, 0, 1'b0, 2'd0, 16'sd0, 1'b0);
    flush(1'b1);
    send(16'sd100, 0, 1'b1, 2'd3, 16'sh2000, 1'b0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) flush(1'($urandom_range(0, 1)));
      else send(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset during MAC cycle 2
    i_data = 16'sd1000; i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rdy", o_data_ready, 1);
    check("mid_rst_vld", o_data_valid, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_sat", o_sat, 0);
    repeat (N + 2) begin
      tick();
      check("mid_rst_novld", o_data_valid, 0);
    end
    reset_n = 1'b1;
    model_clear_all();
    tick();
    impulse_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
